// File: rtl/axi_pkg.sv
`default_nettype none
// axi_pkg -- shared encodings, W FSM state and AW queue entry layout for the AXI write slave.
// Revision 1.0
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;

   typedef enum logic [0:0] {
      W_IDLE = 1'b0,
      W_DATA = 1'b1
   } w_state_e;

   // ID and address ride alongside this struct because their widths are per-instance.
   typedef struct packed {
      logic [7:0] len;
      logic [2:0] size;
      logic [1:0] burst;
   } aw_entry_t;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_write_slave_fsm_if.sv
`default_nettype none
// axi_write_slave_fsm_if -- AXI write-channel bundle (AW, W, B) with manager/subordinate views.
// Revision 1.0
interface axi_write_slave_fsm_if #(
   parameter int AW  = 32,
   parameter int DW  = 64,
   parameter int IDW = 4
);
   logic [IDW-1:0]  axi_awid;
   logic [AW-1:0]   axi_awaddr;
   logic [7:0]      axi_awlen;
   logic [2:0]      axi_awsize;
   logic [1:0]      axi_awburst;
   logic            axi_awvalid;
   logic            axi_awready;
   logic [DW-1:0]   axi_wdata;
   logic [DW/8-1:0] axi_wstrb;
   logic            axi_wlast;
   logic            axi_wvalid;
   logic            axi_wready;
   logic [IDW-1:0]  axi_bid;
   logic [1:0]      axi_bresp;
   logic            axi_bvalid;
   logic            axi_bready;

   modport master (
      output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
      input  axi_awready,
      output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
      input  axi_wready,
      input  axi_bid, axi_bresp, axi_bvalid,
      output axi_bready
   );

   modport slave (
      input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
      output axi_awready,
      input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
      output axi_wready,
      output axi_bid, axi_bresp, axi_bvalid,
      input  axi_bready
   );
endinterface
`default_nettype wire

// File: rtl/axi_sync_fifo.sv
`default_nettype none
// axi_sync_fifo -- single-clock FIFO with occupancy count; push when full / pop when empty are ignored.
// Revision 1.0
module axi_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  wire logic                     clk_i,
   input  wire logic                     rst_ni,
   input  wire logic                     push_i,
   input  wire logic [WIDTH-1:0]         data_i,
   input  wire logic                     pop_i,
   output logic      [WIDTH-1:0]         data_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic      [$clog2(DEPTH):0]   count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push;
   logic             pop;

   assign push = push_i && !full_o;
   assign pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/axi_write_slave_fsm.sv
`default_nettype none
// axi_write_slave_fsm -- AXI write slave: queued AW bursts, per-beat address generation, queued B responses.
// Revision 1.0
module axi_write_slave_fsm
   import axi_pkg::*;
#(
   parameter int AW              = 32,
   parameter int DW              = 64,
   parameter int IDW             = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  wire logic            axi_aclk,
   input  wire logic            axi_aresetn,
   axi_write_slave_fsm_if.slave s_axi,
   output logic                 wr_en,
   output logic [AW-1:0]        wr_addr,
   output logic [DW-1:0]        wr_data,
   output logic [DW/8-1:0]      wr_strb,
   output logic                 busy
);
   localparam int MAX_SIZE = $clog2(DW/8);
   localparam int CW       = $clog2(MAX_OUTSTANDING) + 1;
   localparam int AQ_W     = IDW + AW + $bits(aw_entry_t);
   localparam int BQ_W     = IDW + 2;

   // AW queue
   logic [AQ_W-1:0] aw_din, aw_dout;
   logic            aw_push, aw_pop, aw_full, aw_empty, awready_q, awready_d;
   logic [CW-1:0]   aw_count;
   logic [IDW-1:0]  head_id;
   logic [AW-1:0]   head_addr;
   aw_entry_t       head_ctl;

   assign aw_din  = {s_axi.axi_awid, s_axi.axi_awaddr, s_axi.axi_awlen, s_axi.axi_awsize, s_axi.axi_awburst};
   assign aw_push = s_axi.axi_awvalid && awready_q && !aw_full;
   assign {head_id, head_addr, head_ctl} = aw_dout;

   axi_sync_fifo #(.WIDTH(AQ_W), .DEPTH(MAX_OUTSTANDING)) u_aw_q (
      .clk_i(axi_aclk), .rst_ni(axi_aresetn),
      .push_i(aw_push), .data_i(aw_din), .pop_i(aw_pop), .data_o(aw_dout),
      .full_o(aw_full), .empty_o(aw_empty), .count_o(aw_count)
   );

   assign awready_d = (aw_count + CW'(aw_push) - CW'(aw_pop)) < CW'(MAX_OUTSTANDING);

   // B queue
   logic [BQ_W-1:0] b_din, b_dout;
   logic            b_push, b_pop, b_full, b_empty;
   logic [CW-1:0]   b_count;

   axi_sync_fifo #(.WIDTH(BQ_W), .DEPTH(MAX_OUTSTANDING)) u_b_q (
      .clk_i(axi_aclk), .rst_ni(axi_aresetn),
      .push_i(b_push), .data_i(b_din), .pop_i(b_pop), .data_o(b_dout),
      .full_o(b_full), .empty_o(b_empty), .count_o(b_count)
   );

   assign b_pop             = s_axi.axi_bvalid && s_axi.axi_bready;
   assign s_axi.axi_bvalid  = !b_empty;
   assign s_axi.axi_bid     = b_empty ? '0 : b_dout[BQ_W-1:2];
   assign s_axi.axi_bresp   = b_empty ? '0 : b_dout[1:0];

   // Burst context and W FSM
   w_state_e        state_q, state_d;
   logic [IDW-1:0]  id_q;
   logic [AW-1:0]   addr_q, addr_d, incr, wrap_mask, size_mask;
   logic [7:0]      beats_left_q, len_q;
   logic [2:0]      size_q;
   logic [1:0]      burst_q;
   logic            illegal_q, lasterr_q, illegal, last_err, wready, w_hs;
   logic            wr_en_q;
   logic [AW-1:0]   wr_addr_q;
   logic [DW-1:0]   wr_data_q;
   logic [DW/8-1:0] wr_strb_q;

   assign w_hs     = s_axi.axi_wvalid && wready;
   assign last_err = s_axi.axi_wlast != (beats_left_q == 8'd0);
   assign b_din    = {id_q, (illegal_q || lasterr_q || last_err) ? RESP_SLVERR : RESP_OKAY};

   always_comb begin
      size_mask = (AW'(1) << head_ctl.size) - AW'(1);
      illegal   = (int'(head_ctl.size) > MAX_SIZE) || (head_ctl.burst == 2'd3) ||
                  ((head_ctl.burst == BURST_WRAP) &&
                   (!wrap_len_ok(head_ctl.len) || ((head_addr & size_mask) != '0)));
   end

   // Wrap keeps the upper address bits and lets only the container offset roll over.
   always_comb begin
      incr      = AW'(1) << size_q;
      wrap_mask = (AW'({1'b0, len_q} + 9'd1) << size_q) - AW'(1);
      case (burst_q)
         BURST_INCR: addr_d = addr_q + incr;
         BURST_WRAP: addr_d = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
         default:    addr_d = addr_q;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) state_q <= W_IDLE;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         W_IDLE:  if (!aw_empty) state_d = W_DATA;
         W_DATA:  if (w_hs && (beats_left_q == 8'd0)) state_d = W_IDLE;
         default: state_d = W_IDLE;
      endcase
   end

   always_comb begin
      aw_pop = 1'b0;
      wready = 1'b0;
      b_push = 1'b0;
      case (state_q)
         W_IDLE: aw_pop = !aw_empty;
         W_DATA: begin
            wready = !b_full;
            b_push = s_axi.axi_wvalid && !b_full && (beats_left_q == 8'd0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         awready_q    <= 1'b0;
         id_q         <= '0;
         addr_q       <= '0;
         beats_left_q <= '0;
         len_q        <= '0;
         size_q       <= '0;
         burst_q      <= '0;
         illegal_q    <= 1'b0;
         lasterr_q    <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         wr_strb_q    <= '0;
      end else begin
         awready_q <= awready_d;
         if (aw_pop) begin
            id_q         <= head_id;
            addr_q       <= head_addr;
            beats_left_q <= head_ctl.len;
            len_q        <= head_ctl.len;
            size_q       <= head_ctl.size;
            burst_q      <= head_ctl.burst;
            illegal_q    <= illegal;
            lasterr_q    <= 1'b0;
         end else if (w_hs) begin
            beats_left_q <= beats_left_q - 8'd1;
            addr_q       <= addr_d;
            lasterr_q    <= lasterr_q || last_err;
         end
         wr_en_q <= w_hs && !illegal_q;
         if (w_hs) begin
            wr_addr_q <= addr_q;
            wr_data_q <= s_axi.axi_wdata;
            wr_strb_q <= s_axi.axi_wstrb;
         end
      end
   end

   assign s_axi.axi_awready = awready_q;
   assign s_axi.axi_wready  = wready;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign wr_strb = wr_strb_q;
   assign busy    = !aw_empty || (state_q == W_DATA) || (b_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_axi_write_slave_fsm.sv
`default_nettype none
// tb_axi_write_slave_fsm -- scoreboard bench: expected beats and responses queued at stimulus time.
// Revision 1.0
module tb_axi_write_slave_fsm;
   import axi_pkg::*;

   localparam int AW = 32, DW = 64, IDW = 4, MAXO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi_write_slave_fsm_if #(.AW(AW), .DW(DW), .IDW(IDW)) axi();

   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic [DW/8-1:0] wr_strb;
   logic            busy;

   axi_write_slave_fsm #(.AW(AW), .DW(DW), .IDW(IDW), .MAX_OUTSTANDING(MAXO)) dut (
      .axi_aclk(clk), .axi_aresetn(rst_n), .s_axi(axi),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .busy(busy)
   );

   typedef struct { logic [IDW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } aw_t;
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [DW/8-1:0] strb; } wr_t;
   typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_t;

   aw_t aw_q[$];
   wr_t wr_exp_q[$];
   b_t  b_exp_q[$];
   int  n_checks = 0;
   int  n_fail = 0;

   function automatic logic model_legal(input aw_t a);
      if ((32'd1 << a.size) > 32'(DW/8)) return 1'b0;
      if (a.burst == 2'd3) return 1'b0;
      if (a.burst == BURST_WRAP) begin
         if (!(a.len inside {8'd1, 8'd3, 8'd7, 8'd15})) return 1'b0;
         if ((a.addr % (32'd1 << a.size)) != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [AW-1:0] model_addr(input aw_t a, input int i);
      logic [AW-1:0] bytes, cont, base;
      bytes = 32'd1 << a.size;
      if (a.burst == BURST_FIXED) return a.addr;
      if (a.burst == BURST_INCR)  return a.addr + bytes * 32'(i);
      cont = (32'(a.len) + 32'd1) * bytes;
      base = a.addr - (a.addr % cont);
      return base + (((a.addr % cont) + bytes * 32'(i)) % cont);
   endfunction

   // Scoreboard: memory-port beats and B handshakes against queued expectations.
   always @(negedge clk) begin
      wr_t we;
      b_t  be;
      if (rst_n) begin
         if (wr_en) begin
            n_checks++;
            if (wr_exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL wr_unexpected: wr_en=1 addr=%h, required no write", wr_addr);
            end else begin
               we = wr_exp_q.pop_front();
               if (wr_addr !== we.addr || wr_data !== we.data || wr_strb !== we.strb) begin
                  n_fail++;
                  $display("FAIL wr_beat: addr=%h data=%h strb=%h, required addr=%h data=%h strb=%h",
                           wr_addr, wr_data, wr_strb, we.addr, we.data, we.strb);
               end
            end
         end
         if (axi.axi_bvalid && axi.axi_bready) begin
            n_checks++;
            if (b_exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL b_unexpected: bid=%0d bresp=%0d, required no response", axi.axi_bid, axi.axi_bresp);
            end else begin
               be = b_exp_q.pop_front();
               if (axi.axi_bid !== be.id || axi.axi_bresp !== be.resp) begin
                  n_fail++;
                  $display("FAIL b_resp: bid=%0d bresp=%0d, required bid=%0d bresp=%0d",
                           axi.axi_bid, axi.axi_bresp, be.id, be.resp);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_aw(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      aw_t a;
      int  n;
      a.id = id; a.addr = addr; a.len = len; a.size = size; a.burst = burst;
      axi.axi_awid = id; axi.axi_awaddr = addr; axi.axi_awlen = len;
      axi.axi_awsize = size; axi.axi_awburst = burst; axi.axi_awvalid = 1'b1;
      n = 0;
      while (axi.axi_awready !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) begin
         n_checks++; n_fail++;
         $display("FAIL aw_timeout: awready=%b after 50 cycles, required 1", axi.axi_awready);
      end else begin
         tick();
         aw_q.push_back(a);
      end
      axi.axi_awvalid = 1'b0;
   endtask

   // last_at < 0: WLAST on the final beat; max_beats < 0: drive the whole burst.
   task automatic send_w_burst(input int last_at, input int max_beats);
      aw_t             a;
      b_t              be;
      wr_t             we;
      logic            legal, err;
      logic [DW-1:0]   d;
      logic [DW/8-1:0] s;
      int              n, nb;
      if (aw_q.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL w_no_aw: 0 bursts issued, required at least 1");
         return;
      end
      a     = aw_q.pop_front();
      legal = model_legal(a);
      err   = !legal || (last_at >= 0 && last_at != int'(a.len));
      be.id = a.id; be.resp = err ? 2'd2 : 2'd0;
      b_exp_q.push_back(be);
      nb = (max_beats < 0) ? int'(a.len) + 1 : max_beats;
      for (int i = 0; i < nb; i++) begin
         d = {$urandom, $urandom};
         s = 8'($urandom);
         if (legal) begin
            we.addr = model_addr(a, i); we.data = d; we.strb = s;
            wr_exp_q.push_back(we);
         end
         axi.axi_wvalid = 1'b1; axi.axi_wdata = d; axi.axi_wstrb = s;
         axi.axi_wlast  = (last_at < 0) ? (i == int'(a.len)) : (i == last_at);
         n = 0;
         while (axi.axi_wready !== 1'b1 && n < 50) begin tick(); n++; end
         if (n >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL w_timeout: wready=%b on beat %0d, required 1", axi.axi_wready, i);
            axi.axi_wvalid = 1'b0;
            return;
         end
         tick();
         n_checks++;
         if (wr_en !== legal) begin
            n_fail++;
            $display("FAIL wr_latency: wr_en=%b one cycle after beat %0d, required %b", wr_en, i, legal);
         end
      end
      axi.axi_wvalid = 1'b0;
      axi.axi_wlast  = 1'b0;
   endtask

   task automatic wait_b_drain();
      int n;
      n = 0;
      while (b_exp_q.size() != 0 && n < 100) begin tick(); n++; end
      tick();
      n_checks++;
      if (b_exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b_drain: %0d responses outstanding, required 0", b_exp_q.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_checks++;
      if ({axi.axi_awready, axi.axi_wready, axi.axi_bvalid, wr_en, busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: awready/wready/bvalid/wr_en/busy=%b, required 00000",
                  {axi.axi_awready, axi.axi_wready, axi.axi_bvalid, wr_en, busy});
      end
      n_checks++;
      if (axi.axi_bid !== '0 || axi.axi_bresp !== '0 || wr_addr !== '0 || wr_data !== '0 || wr_strb !== '0) begin
         n_fail++;
         $display("FAIL reset_data: bid=%h bresp=%h wr_addr=%h wr_data=%h wr_strb=%h, required all 0",
                  axi.axi_bid, axi.axi_bresp, wr_addr, wr_data, wr_strb);
      end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (axi.axi_awready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_awready: awready=%b first cycle after release, required 1", axi.axi_awready);
      end
   endtask

   task automatic test_incr();
      send_aw(4'd3, 32'h100, 8'd3, 3'd3, BURST_INCR);
      send_w_burst(-1, -1);
      wait_b_drain();
   endtask

   task automatic test_wrap_and_illegal();
      send_aw(4'd5, 32'h38, 8'd3, 3'd3, BURST_WRAP);  send_w_burst(-1, -1);
      send_aw(4'd6, 32'h3C, 8'd3, 3'd3, BURST_WRAP);  send_w_burst(-1, -1);
      send_aw(4'd7, 32'h104, 8'd1, 3'd2, BURST_WRAP); send_w_burst(-1, -1);
      send_aw(4'd1, 32'h700, 8'd0, 3'd4, BURST_INCR); send_w_burst(-1, -1);
      send_aw(4'd2, 32'h800, 8'd1, 3'd3, 2'd3);       send_w_burst(-1, -1);
      send_aw(4'd3, 32'h900, 8'd2, 3'd3, BURST_WRAP); send_w_burst(-1, -1);
      send_aw(4'd4, 32'hA00, 8'd1, 3'd3, BURST_FIXED); send_w_burst(-1, -1);
      wait_b_drain();
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 5; i++) send_aw(4'(i), 32'h1000 + 32'(i) * 32'h100, 8'd1, 3'd3, BURST_INCR);
      tick();
      n_checks++;
      if (axi.axi_awready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_full: awready=%b busy=%b, required awready=0 busy=1", axi.axi_awready, busy);
      end
      for (int i = 0; i < 5; i++) send_w_burst(-1, -1);
      wait_b_drain();
      n_checks++;
      if (axi.axi_awready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drained: awready=%b busy=%b, required awready=1 busy=0", axi.axi_awready, busy);
      end
   endtask

   task automatic test_wlast_error();
      send_aw(4'd7, 32'h200, 8'd3, 3'd2, BURST_INCR);
      send_w_burst(1, -1);
      send_aw(4'd8, 32'h300, 8'd0, 3'd3, BURST_INCR);
      send_w_burst(-1, -1);
      wait_b_drain();
   endtask

   task automatic test_b_backpressure();
      axi.axi_bready = 1'b0;
      for (int i = 0; i < 5; i++) send_aw(4'(9 + i), 32'h400 + 32'(i) * 32'h8, 8'd0, 3'd3, BURST_FIXED);
      for (int i = 0; i < 4; i++) send_w_burst(-1, -1);
      tick(); tick();
      n_checks++;
      if (axi.axi_wready !== 1'b0 || axi.axi_bvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL bfull_hold: wready=%b bvalid=%b, required wready=0 bvalid=1", axi.axi_wready, axi.axi_bvalid);
      end
      fork
         send_w_burst(-1, -1);
         begin
            repeat (4) begin
               tick();
               n_checks++;
               if (axi.axi_wready !== 1'b0) begin
                  n_fail++;
                  $display("FAIL bfull_wready: wready=%b with B queue full, required 0", axi.axi_wready);
               end
            end
            axi.axi_bready = 1'b1;
         end
      join
      wait_b_drain();
   endtask

   task automatic test_reset_mid_burst();
      send_aw(4'd14, 32'h500, 8'd3, 3'd3, BURST_INCR);
      send_w_burst(-1, 2);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({axi.axi_bvalid, axi.axi_awready, axi.axi_wready, wr_en, busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL midrst_ctrl: bvalid/awready/wready/wr_en/busy=%b, required 00000",
                  {axi.axi_bvalid, axi.axi_awready, axi.axi_wready, wr_en, busy});
      end
      wr_exp_q.delete();
      b_exp_q.delete();
      aw_q.delete();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (axi.axi_awready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_awready: awready=%b after release, required 1", axi.axi_awready);
      end
      send_aw(4'd15, 32'h600, 8'd1, 3'd3, BURST_INCR);
      send_w_burst(-1, -1);
      wait_b_drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      axi.axi_awid = '0; axi.axi_awaddr = '0; axi.axi_awlen = '0; axi.axi_awsize = '0;
      axi.axi_awburst = '0; axi.axi_awvalid = 1'b0;
      axi.axi_wdata = '0; axi.axi_wstrb = '0; axi.axi_wlast = 1'b0; axi.axi_wvalid = 1'b0;
      axi.axi_bready = 1'b1;
      test_reset();
      test_incr();
      test_wrap_and_illegal();
      test_back_to_back();
      test_wlast_error();
      test_b_backpressure();
      test_reset_mid_burst();
      n_checks++;
      if (wr_exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL wr_leftover: %0d expected beats never written, required 0", wr_exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
